divider: RTL and testbench

DIVIDER -- requirements
Module: divider

---
 rtl/divider_if.sv | 23 ++
 rtl/divider.sv | 160 ++++++++++++++++
 tb/tb_divider.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/divider_if.sv
// Handshake/data bundle between the EX stage and the iterative divider.
interface divider_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic                 signed_div;
    logic [WIDTH-1:0]     opdata1;
    logic [WIDTH-1:0]     opdata2;
    logic                 annul;
    logic [2*WIDTH-1:0]   result;
    logic                 ready;
    logic                 busy;

    modport master (
        output start, signed_div, opdata1, opdata2, annul,
        input  result, ready, busy
    );

    modport slave (
        input  start, signed_div, opdata1, opdata2, annul,
        output result, ready, busy
    );
endinterface

// File: rtl/divider.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle.
// result = {remainder, quotient}; signed mode works on magnitudes and
// fixes the signs after the last iteration. A zero divisor skips the
// iterations and reports a zero result two cycles after start.
module divider #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst,
    divider_if.slave  bus
);

    localparam int              CW        = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]   CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    state_t               state_r;
    logic [CW-1:0]        count_r;
    logic [WIDTH-1:0]     rem_r;
    logic [WIDTH-1:0]     quo_r;
    logic [WIDTH-1:0]     dvs_r;
    logic                 neg_q_r;
    logic                 neg_r_r;
    logic [2*WIDTH-1:0]   result_r;
    logic                 ready_r;

    logic [WIDTH-1:0]     abs_a_s;
    logic [WIDTH-1:0]     abs_b_s;
    logic [WIDTH:0]       shift_s;
    logic [WIDTH:0]       diff_s;
    logic [WIDTH-1:0]     rem_next_s;
    logic [WIDTH-1:0]     quo_next_s;
    logic [WIDTH-1:0]     quo_fix_s;
    logic [WIDTH-1:0]     rem_fix_s;

    // Operand magnitudes taken at start (signed mode only).
    always_comb begin
        if (bus.signed_div && bus.opdata1[WIDTH-1]) begin
            abs_a_s = {WIDTH{1'b0}} - bus.opdata1;
        end else begin
            abs_a_s = bus.opdata1;
        end
        if (bus.signed_div && bus.opdata2[WIDTH-1]) begin
            abs_b_s = {WIDTH{1'b0}} - bus.opdata2;
        end else begin
            abs_b_s = bus.opdata2;
        end
    end

    // One restoring step: shift in the next dividend bit, trial-subtract,
    // keep the difference when it did not go negative.
    always_comb begin
        shift_s = {rem_r, quo_r[WIDTH-1]};
        diff_s  = shift_s - {1'b0, dvs_r};
        if (diff_s[WIDTH] == 1'b0) begin
            rem_next_s = diff_s[WIDTH-1:0];
        end else begin
            rem_next_s = shift_s[WIDTH-1:0];
        end
        quo_next_s = {quo_r[WIDTH-2:0], ~diff_s[WIDTH]};
    end

    // Sign correction of the final step's outputs; most-negative / -1 wraps naturally.
    always_comb begin
        if (neg_q_r) begin
            quo_fix_s = {WIDTH{1'b0}} - quo_next_s;
        end else begin
            quo_fix_s = quo_next_s;
        end
        if (neg_r_r) begin
            rem_fix_s = {WIDTH{1'b0}} - rem_next_s;
        end else begin
            rem_fix_s = rem_next_s;
        end
    end

    // Control FSM with datapath registers; annul beats the final iteration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            count_r  <= CNT_ZERO;
            rem_r    <= {WIDTH{1'b0}};
            quo_r    <= {WIDTH{1'b0}};
            dvs_r    <= {WIDTH{1'b0}};
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            result_r <= {(2*WIDTH){1'b0}};
            ready_r  <= 1'b0;
        end else begin
            ready_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        count_r <= CNT_ZERO;
                        if (bus.opdata2 == {WIDTH{1'b0}}) begin
                            state_r <= BYZERO;
                        end else begin
                            rem_r   <= {WIDTH{1'b0}};
                            quo_r   <= abs_a_s;
                            dvs_r   <= abs_b_s;
                            neg_q_r <= bus.signed_div & (bus.opdata1[WIDTH-1] ^ bus.opdata2[WIDTH-1]);
                            neg_r_r <= bus.signed_div & bus.opdata1[WIDTH-1];
                            state_r <= ON;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BYZERO: begin
                    // Two cycles here so the zero result is reported at start+2.
                    if (bus.annul) begin
                        state_r <= IDLE;
                    end else if (count_r == CNT_ZERO) begin
                        count_r <= CNT_ONE;
                    end else begin
                        result_r <= {(2*WIDTH){1'b0}};
                        ready_r  <= 1'b1;
                        state_r  <= END;
                    end
                end
                ON: begin
                    if (bus.annul) begin
                        state_r <= IDLE;
                    end else begin
                        rem_r   <= rem_next_s;
                        quo_r   <= quo_next_s;
                        count_r <= count_r + CNT_ONE;
                        if (count_r == CNT_LAST) begin
                            result_r <= {rem_fix_s, quo_fix_s};
                            ready_r  <= 1'b1;
                            state_r  <= END;
                        end else begin
                            state_r <= ON;
                        end
                    end
                end
                END: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.result = result_r;
    assign bus.ready  = ready_r;
    assign bus.busy   = !rst && ((state_r == ON) || (state_r == BYZERO) ||
                                 ((state_r == IDLE) && bus.start));

endmodule

// File: tb/tb_divider.sv
// Directed testbench for the iterative divider.
module tb_divider;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    divider_if #(.WIDTH(32)) bus ();

    divider #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request, sample the combinational busy, pass edge E0, drop start.
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          output logic pre_busy);
        bus.start      = 1'b1;
        bus.opdata1    = a;
        bus.opdata2    = b;
        bus.signed_div = sgn;
        #1;
        pre_busy = bus.busy;
        tick();
        bus.start = 1'b0;
    endtask

    // Observe n cycles: first ready offset, ready pulse count, busy cycles, first result.
    task automatic run_cycles(input int n, output int ready_at, output int pulses,
                              output int busy_cnt, output logic [63:0] res);
        ready_at = -1;
        pulses   = 0;
        busy_cnt = 0;
        res      = 64'd0;
        for (int k = 0; k < n; k++) begin
            if (bus.ready) begin
                pulses++;
                if (ready_at < 0) begin
                    ready_at = k;
                    res      = bus.result;
                end
            end
            if (bus.busy) busy_cnt++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.opdata2 = 32'd5;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", bus.ready); end
        checks++; if (bus.result !== 64'd0) begin errors++; $display("FAIL reset_result: got %h want 0", bus.result); end
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", bus.busy); end
        bus.start = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL idle_start_busy: got %b want 1", bus.busy); end
        bus.start = 1'b0;
        tick();
    endtask

    task automatic test_unsigned_basic();
        logic pb; int ra; int p; int bc; logic [63:0] res;
        launch(32'd100, 32'd7, 1'b0, pb);
        run_cycles(40, ra, p, bc, res);
        checks++; if (ra !== 32) begin errors++; $display("FAIL u100_7_latency: got %0d want 32", ra); end
        checks++; if (p !== 1) begin errors++; $display("FAIL u100_7_pulses: got %0d want 1", p); end
        checks++; if ((bc + (pb ? 1 : 0)) !== 33) begin errors++; $display("FAIL u100_7_busy_cycles: got %0d want 33", bc + (pb ? 1 : 0)); end
        checks++; if (res !== {32'd2, 32'd14}) begin errors++; $display("FAIL u100_7_result: got %h want %h", res, {32'd2, 32'd14}); end
        checks++; if (bus.result !== {32'd2, 32'd14}) begin errors++; $display("FAIL u100_7_hold: got %h want %h", bus.result, {32'd2, 32'd14}); end
    endtask

    task automatic test_vectors();
        logic [31:0] va [8];
        logic [31:0] vb [8];
        logic        vs [8];
        logic [63:0] ve [8];
        logic pb; int ra; int p; int bc; logic [63:0] res;
        va = '{32'hFFFFFFF9, 32'h00000007, 32'h80000000, 32'h80000000,
               32'hFFFFFF9C, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'h00000001};
        vb = '{32'h00000002, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'hFFFFFFF9, 32'h00000010, 32'h00000002, 32'hFFFFFFFF};
        vs = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        ve = '{{32'hFFFFFFFF, 32'hFFFFFFFD}, {32'h00000001, 32'hFFFFFFFD},
               {32'h00000000, 32'h80000000}, {32'h80000000, 32'h00000000},
               {32'hFFFFFFFE, 32'h0000000E}, {32'h0000000F, 32'h0FFFFFFF},
               {32'h00000001, 32'h7FFFFFFC}, {32'h00000001, 32'h00000000}};
        for (int i = 0; i < 8; i++) begin
            launch(va[i], vb[i], vs[i], pb);
            run_cycles(36, ra, p, bc, res);
            checks++; if (ra !== 32) begin errors++; $display("FAIL vec%0d_latency: got %0d want 32", i, ra); end
            checks++; if (res !== ve[i]) begin errors++; $display("FAIL vec%0d_result: got %h want %h", i, res, ve[i]); end
        end
    endtask

    task automatic test_annul_mid();
        logic pb; int ra; int p; int bc; logic [63:0] res;
        launch(32'd1000, 32'd9, 1'b0, pb);
        run_cycles(9, ra, p, bc, res);
        bus.annul = 1'b1;
        tick();
        bus.annul = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL annul_mid_busy: got %b want 0", bus.busy); end
        checks++; if (bus.result !== {32'd1, 32'd0}) begin errors++; $display("FAIL annul_mid_result_kept: got %h want %h", bus.result, {32'd1, 32'd0}); end
        launch(32'd6, 32'd3, 1'b0, pb);
        run_cycles(40, ra, p, bc, res);
        checks++; if (ra !== 32 || p !== 1) begin errors++; $display("FAIL annul_then_6_3_timing: got at=%0d pulses=%0d want at=32 pulses=1", ra, p); end
        checks++; if (res !== {32'd0, 32'd2}) begin errors++; $display("FAIL annul_then_6_3_result: got %h want %h", res, {32'd0, 32'd2}); end
    endtask

    task automatic test_annul_last();
        logic pb; int ra; int p; int bc; logic [63:0] res;
        launch(32'd77, 32'd5, 1'b0, pb);
        run_cycles(31, ra, p, bc, res);
        bus.annul = 1'b1;
        tick();
        bus.annul = 1'b0;
        checks++; if (bus.ready !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL annul_last_state: got ready=%b busy=%b want 0 0", bus.ready, bus.busy); end
        run_cycles(6, ra, p, bc, res);
        checks++; if (p !== 0) begin errors++; $display("FAIL annul_last_pulses: got %0d want 0", p); end
        checks++; if (bus.result !== {32'd0, 32'd2}) begin errors++; $display("FAIL annul_last_result_kept: got %h want %h", bus.result, {32'd0, 32'd2}); end
    endtask

    task automatic test_annul_byzero();
        logic pb; int ra; int p; int bc; logic [63:0] res;
        launch(32'd5, 32'd0, 1'b0, pb);
        bus.annul = 1'b1;
        tick();
        bus.annul = 1'b0;
        run_cycles(6, ra, p, bc, res);
        checks++; if (p !== 0) begin errors++; $display("FAIL annul_byzero_pulses: got %0d want 0", p); end
        checks++; if (bus.result !== {32'd0, 32'd2}) begin errors++; $display("FAIL annul_byzero_result_kept: got %h want %h", bus.result, {32'd0, 32'd2}); end
    endtask

    task automatic test_div_by_zero();
        logic pb; int ra; int p; int bc; logic [63:0] res;
        launch(32'd123, 32'd0, 1'b0, pb);
        run_cycles(8, ra, p, bc, res);
        checks++; if (ra !== 2 || p !== 1) begin errors++; $display("FAIL byzero_timing: got at=%0d pulses=%0d want at=2 pulses=1", ra, p); end
        checks++; if (res !== 64'd0) begin errors++; $display("FAIL byzero_result: got %h want 0", res); end
        checks++; if ((bc + (pb ? 1 : 0)) !== 3) begin errors++; $display("FAIL byzero_busy_cycles: got %0d want 3", bc + (pb ? 1 : 0)); end
        // start held high through END: one pulse, re-accepted once back in IDLE
        bus.start   = 1'b1;
        bus.opdata1 = 32'd9;
        bus.opdata2 = 32'd0;
        tick();
        run_cycles(4, ra, p, bc, res);
        checks++; if (ra !== 2 || p !== 1) begin errors++; $display("FAIL byzero_held_first: got at=%0d pulses=%0d want at=2 pulses=1", ra, p); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL byzero_held_reaccept: got busy=%b want 1", bus.busy); end
        bus.start = 1'b0;
        run_cycles(5, ra, p, bc, res);
        checks++; if (ra !== 2 || p !== 1) begin errors++; $display("FAIL byzero_held_second: got at=%0d pulses=%0d want at=2 pulses=1", ra, p); end
    endtask

    task automatic test_back_to_back();
        logic pb; int ra; int p; int bc; logic [63:0] res;
        launch(32'd100, 32'd7, 1'b0, pb);
        run_cycles(5, ra, p, bc, res);
        bus.start   = 1'b1;
        bus.opdata1 = 32'd1;
        bus.opdata2 = 32'd1;
        run_cycles(6, ra, p, bc, res);
        bus.start = 1'b0;
        run_cycles(26, ra, p, bc, res);
        checks++; if (ra !== 21 || p !== 1) begin errors++; $display("FAIL ignore_start_timing: got at=%0d pulses=%0d want at=21 pulses=1", ra, p); end
        checks++; if (res !== {32'd2, 32'd14}) begin errors++; $display("FAIL ignore_start_result: got %h want %h", res, {32'd2, 32'd14}); end
    endtask

    task automatic test_reset_mid_on();
        logic pb; int ra; int p; int bc; logic [63:0] res;
        launch(32'd50, 32'd3, 1'b0, pb);
        run_cycles(14, ra, p, bc, res);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.result !== 64'd0) begin errors++; $display("FAIL rst_mid_result: got %h want 0", bus.result); end
        checks++; if (bus.busy !== 1'b0 || bus.ready !== 1'b0) begin errors++; $display("FAIL rst_mid_flags: got busy=%b ready=%b want 0 0", bus.busy, bus.ready); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        run_cycles(40, ra, p, bc, res);
        checks++; if (p !== 0) begin errors++; $display("FAIL rst_mid_no_ready: got %0d pulses want 0", p); end
        launch(32'd9, 32'd4, 1'b0, pb);
        run_cycles(40, ra, p, bc, res);
        checks++; if (ra !== 32) begin errors++; $display("FAIL rst_then_9_4_latency: got %0d want 32", ra); end
        checks++; if (res !== {32'd1, 32'd2}) begin errors++; $display("FAIL rst_then_9_4_result: got %h want %h", res, {32'd1, 32'd2}); end
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        clk            = 1'b0;
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.signed_div = 1'b0;
        bus.opdata1    = 32'd0;
        bus.opdata2    = 32'd0;
        bus.annul      = 1'b0;
        test_reset();
        test_unsigned_basic();
        test_vectors();
        test_annul_mid();
        test_annul_last();
        test_annul_byzero();
        test_div_by_zero();
        test_back_to_back();
        test_reset_mid_on();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
